// File: rtl/ex_issue_stage.sv
// rtl/ex_issue_stage.sv - execute-stage holding register and multi-cycle unit issue controller
module ex_issue_stage #(
    parameter int PAYLOAD_W = 128,
    parameter int NUM_UNITS = 2,
    parameter int ADDR_W    = 32,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [NUM_UNITS-1:0] in_unit_sel,
    input  logic                 in_mem_en,
    input  logic [1:0]           in_mem_size,
    input  logic [ADDR_W-1:0]    in_addr,
    input  logic                 in_exc,
    input  logic [5:0]           in_ecode,
    input  logic [8:0]           in_esubcode,
    input  logic                 flush,
    output logic [NUM_UNITS-1:0] unit_req_valid,
    input  logic [NUM_UNITS-1:0] unit_req_ready,
    output logic [NUM_UNITS-1:0] unit_cancel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [NUM_UNITS-1:0] out_unit_sel,
    output logic                 out_exc,
    output logic [5:0]           out_ecode,
    output logic [8:0]           out_esubcode,
    output logic [ADDR_W-1:0]    out_badv,
    output logic [CNT_W-1:0]     stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [5:0] ECODE_ALE = 6'h09;

    state_t                 state_q;
    logic [PAYLOAD_W-1:0]   payload_q;
    logic [NUM_UNITS-1:0]   unit_sel_q;
    logic [NUM_UNITS-1:0]   out_unit_sel_q;
    logic                   issued_q;
    logic                   exc_q;
    logic [5:0]             ecode_q;
    logic [8:0]             esubcode_q;
    logic [ADDR_W-1:0]      badv_q;
    logic [NUM_UNITS-1:0]   cancel_q;
    logic [CNT_W-1:0]       stall_cnt_q;

    logic [ADDR_W-1:0]      align_mask;
    logic                   ale;
    logic                   exc_d;
    logic [5:0]             ecode_d;
    logic [8:0]             esubcode_d;
    logic                   load;
    logic                   grant;
    logic                   stall;
    logic [CNT_W-1:0]       stall_cnt_d;
    logic [NUM_UNITS-1:0]   cancel_d;

    // Low log2(size) address bits must be zero for an aligned access.
    always_comb begin
        align_mask = ~({ADDR_W{1'b1}} << in_mem_size);
        ale        = in_mem_en && ((in_addr & align_mask) != '0);
        exc_d      = in_exc || ale;
        ecode_d    = in_ecode;
        esubcode_d = in_esubcode;
        if (ale && !in_exc) begin
            ecode_d    = ECODE_ALE;
            esubcode_d = '0;
        end
    end

    assign in_ready       = (state_q == EMPTY) || ((state_q == DONE) && out_ready);
    assign out_valid      = (state_q == DONE) && !flush;
    assign unit_req_valid = ((state_q == ISSUE) && !flush) ? unit_sel_q : '0;

    assign load  = in_valid && in_ready && !flush;
    assign grant = (state_q == ISSUE) && !flush && ((unit_sel_q & unit_req_ready) != '0);
    assign stall = (state_q == ISSUE) && !flush && !grant;

    assign stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

    // A unit that already accepted the flushed instruction must discard its result.
    assign cancel_d = (flush && (state_q == DONE) && issued_q) ? out_unit_sel_q : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= EMPTY;
            payload_q      <= '0;
            unit_sel_q     <= '0;
            out_unit_sel_q <= '0;
            issued_q       <= 1'b0;
            exc_q          <= 1'b0;
            ecode_q        <= '0;
            esubcode_q     <= '0;
            badv_q         <= '0;
            cancel_q       <= '0;
            stall_cnt_q    <= '0;
        end else begin
            cancel_q    <= cancel_d;
            stall_cnt_q <= stall_cnt_d;
            if (flush) begin
                state_q <= EMPTY;
            end else if (load) begin
                payload_q      <= in_payload;
                unit_sel_q     <= in_unit_sel;
                out_unit_sel_q <= '0;
                issued_q       <= 1'b0;
                exc_q          <= exc_d;
                ecode_q        <= ecode_d;
                esubcode_q     <= esubcode_d;
                badv_q         <= in_addr;
                state_q        <= (exc_d || (in_unit_sel == '0)) ? DONE : ISSUE;
            end else begin
                case (state_q)
                    ISSUE: begin
                        if (grant) begin
                            issued_q       <= 1'b1;
                            out_unit_sel_q <= unit_sel_q;
                            state_q        <= DONE;
                        end
                    end
                    DONE: begin
                        if (out_ready) begin
                            state_q <= EMPTY;
                        end
                    end
                    default: state_q <= state_q;
                endcase
            end
        end
    end

    assign out_payload  = payload_q;
    assign out_unit_sel = out_unit_sel_q;
    assign out_exc      = exc_q;
    assign out_ecode    = ecode_q;
    assign out_esubcode = esubcode_q;
    assign out_badv     = badv_q;
    assign unit_cancel  = cancel_q;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_ex_issue_stage.sv
// tb/tb_ex_issue_stage.sv - directed bench for ex_issue_stage with a transaction-level reference model
module tb_ex_issue_stage;

    localparam int PW = 128;
    localparam int NU = 2;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          in_valid = 1'b0;
    logic [PW-1:0] in_payload = '0;
    logic [NU-1:0] in_unit_sel = '0;
    logic          in_mem_en = 1'b0;
    logic [1:0]    in_mem_size = '0;
    logic [AW-1:0] in_addr = '0;
    logic          in_exc = 1'b0;
    logic [5:0]    in_ecode = '0;
    logic [8:0]    in_esubcode = '0;
    logic          flush = 1'b0;
    logic [NU-1:0] unit_req_ready = '0;
    logic          out_ready = 1'b1;

    logic          in_ready, out_valid, out_exc;
    logic [NU-1:0] unit_req_valid, unit_cancel, out_unit_sel;
    logic [PW-1:0] out_payload;
    logic [5:0]    out_ecode;
    logic [8:0]    out_esubcode;
    logic [AW-1:0] out_badv;
    logic [15:0]   stall_cnt;

    logic          s_in_ready, s_out_valid, s_out_exc;
    logic [NU-1:0] s_req_valid, s_cancel, s_out_unit_sel;
    logic [PW-1:0] s_out_payload;
    logic [5:0]    s_out_ecode;
    logic [8:0]    s_out_esubcode;
    logic [AW-1:0] s_out_badv;
    logic [3:0]    s_stall_cnt;

    always #5 clk = ~clk;

    ex_issue_stage #(.PAYLOAD_W(PW), .NUM_UNITS(NU), .ADDR_W(AW), .CNT_W(16)) u_dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_payload(in_payload), .in_unit_sel(in_unit_sel), .in_mem_en(in_mem_en),
        .in_mem_size(in_mem_size), .in_addr(in_addr), .in_exc(in_exc), .in_ecode(in_ecode),
        .in_esubcode(in_esubcode), .flush(flush), .unit_req_valid(unit_req_valid),
        .unit_req_ready(unit_req_ready), .unit_cancel(unit_cancel), .out_valid(out_valid),
        .out_ready(out_ready), .out_payload(out_payload), .out_unit_sel(out_unit_sel),
        .out_exc(out_exc), .out_ecode(out_ecode), .out_esubcode(out_esubcode),
        .out_badv(out_badv), .stall_cnt(stall_cnt)
    );

    ex_issue_stage #(.PAYLOAD_W(PW), .NUM_UNITS(NU), .ADDR_W(AW), .CNT_W(4)) u_dut_small (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_payload(in_payload), .in_unit_sel(in_unit_sel), .in_mem_en(in_mem_en),
        .in_mem_size(in_mem_size), .in_addr(in_addr), .in_exc(in_exc), .in_ecode(in_ecode),
        .in_esubcode(in_esubcode), .flush(flush), .unit_req_valid(s_req_valid),
        .unit_req_ready(unit_req_ready), .unit_cancel(s_cancel), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_payload(s_out_payload), .out_unit_sel(s_out_unit_sel),
        .out_exc(s_out_exc), .out_ecode(s_out_ecode), .out_esubcode(s_out_esubcode),
        .out_badv(s_out_badv), .stall_cnt(s_stall_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit misaligned(input bit en, input logic [AW-1:0] a, input logic [1:0] sz);
        int unsigned bytes;
        bytes = 1 << sz;
        return en && ((a % bytes) != 0);
    endfunction

    // Model: one slot that is either empty, waiting for a unit grant, or holding a result.
    bit            m_full, m_wait;
    logic [PW-1:0] m_payload;
    logic [NU-1:0] m_sel, m_granted, m_cancel;
    bit            m_exc;
    logic [5:0]    m_ecode;
    logic [8:0]    m_esub;
    logic [AW-1:0] m_badv;
    int            m_stalls;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_full <= 0; m_wait <= 0; m_payload <= '0; m_sel <= '0; m_granted <= '0;
            m_cancel <= '0; m_exc <= 0; m_ecode <= '0; m_esub <= '0; m_badv <= '0; m_stalls <= 0;
        end else begin
            m_cancel <= (flush && m_full && !m_wait && m_granted != 0) ? m_granted : '0;
            if (flush) begin
                m_full <= 0;
                m_wait <= 0;
            end else if (m_full && m_wait) begin
                if ((m_sel & unit_req_ready) != 0) begin
                    m_wait    <= 0;
                    m_granted <= m_sel;
                end else begin
                    m_stalls <= m_stalls + 1;
                end
            end else if (in_valid && (!m_full || out_ready)) begin
                m_full    <= 1;
                m_payload <= in_payload;
                m_sel     <= in_unit_sel;
                m_granted <= '0;
                m_exc     <= in_exc || misaligned(in_mem_en, in_addr, in_mem_size);
                m_wait    <= !(in_exc || misaligned(in_mem_en, in_addr, in_mem_size)) && (in_unit_sel != 0);
                m_ecode   <= (!in_exc && misaligned(in_mem_en, in_addr, in_mem_size)) ? 6'h09 : in_ecode;
                m_esub    <= (!in_exc && misaligned(in_mem_en, in_addr, in_mem_size)) ? 9'h0 : in_esubcode;
                m_badv    <= in_addr;
            end else if (m_full && out_ready) begin
                m_full <= 0;
            end
        end
    end

    always @(negedge clk) begin
        bit exp_valid;
        exp_valid = m_full && !m_wait && !flush;
        chk("m_in_ready", in_ready, !m_full || (!m_wait && out_ready));
        chk("m_out_valid", out_valid, exp_valid);
        chk("m_req_valid", unit_req_valid, (m_full && m_wait && !flush) ? m_sel : '0);
        chk("m_cancel", unit_cancel, m_cancel);
        chk("m_stall", stall_cnt, (m_stalls > 65535) ? 65535 : m_stalls);
        chk("m_stall4", s_stall_cnt, (m_stalls > 15) ? 15 : m_stalls);
        if (exp_valid) begin
            chk("m_payload", out_payload, m_payload);
            chk("m_unit_sel", out_unit_sel, m_granted);
            chk("m_exc", out_exc, m_exc);
            chk("m_ecode", out_ecode, m_ecode);
            chk("m_esub", out_esubcode, m_esub);
            chk("m_badv", out_badv, m_badv);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req", unit_req_valid, 0);
        chk("rst_cancel", unit_cancel, 0);
        chk("rst_payload", out_payload, 0);
        chk("rst_exc", out_exc, 0);
        chk("rst_badv", out_badv, 0);
        chk("rst_stall", stall_cnt, 0);
        tick(); tick();
        resetn = 1'b1;

        // ALU stream, back-to-back
        in_valid = 1; out_ready = 1; in_unit_sel = 2'b00; in_mem_en = 0;
        for (int i = 0; i < 4; i++) begin
            in_payload = 128'hA0 + 128'(i);
            #1 chk("alu_in_ready", in_ready, 1);
            tick();
            chk("alu_valid", out_valid, 1);
            chk("alu_payload", out_payload, 128'hA0 + 128'(i));
        end
        in_valid = 0;
        tick();
        chk("alu_drain", out_valid, 0);
        chk("alu_stall", stall_cnt, 0);

        // Mul with three stalled cycles
        in_valid = 1; in_payload = 128'hB1; in_unit_sel = 2'b01; unit_req_ready = 2'b00;
        tick();
        in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("mul_req_wait", unit_req_valid, 2'b01);
            chk("mul_not_valid", out_valid, 0);
            tick();
        end
        unit_req_ready = 2'b01;
        #1 chk("mul_req_grant", unit_req_valid, 2'b01);
        tick();
        unit_req_ready = 2'b00;
        chk("mul_done_valid", out_valid, 1);
        chk("mul_unit_sel", out_unit_sel, 2'b01);
        chk("mul_stall", stall_cnt, 3);
        tick();

        // Misaligned word store, then aligned half, then upstream exception wins
        in_valid = 1; in_payload = 128'hC1; in_unit_sel = 2'b01; in_mem_en = 1;
        in_mem_size = 2'd2; in_addr = 32'h1000_0002;
        tick();
        chk("ale_req", unit_req_valid, 0);
        chk("ale_exc", out_exc, 1);
        chk("ale_ecode", out_ecode, 6'h09);
        chk("ale_esub", out_esubcode, 0);
        chk("ale_badv", out_badv, 32'h1000_0002);
        chk("ale_unit_sel", out_unit_sel, 0);
        in_payload = 128'hC2; in_unit_sel = 2'b00; in_mem_size = 2'd1;
        tick();
        chk("half_exc", out_exc, 0);
        chk("half_valid", out_valid, 1);
        in_payload = 128'hC3; in_mem_size = 2'd3; in_addr = 32'h1000_0004;
        in_exc = 1; in_ecode = 6'h0A; in_esubcode = 9'h1FF;
        tick();
        chk("upexc_ecode", out_ecode, 6'h0A);
        chk("upexc_esub", out_esubcode, 9'h1FF);
        chk("upexc_badv", out_badv, 32'h1000_0004);
        in_valid = 0; in_exc = 0; in_mem_en = 0; in_ecode = 0; in_esubcode = 0;
        tick();

        // Div issued, held, then flushed in DONE
        in_valid = 1; in_payload = 128'hD1; in_unit_sel = 2'b10; unit_req_ready = 2'b10;
        tick();
        in_valid = 0;
        #1 chk("div_req", unit_req_valid, 2'b10);
        out_ready = 0;
        tick();
        chk("div_valid", out_valid, 1);
        chk("div_unit_sel", out_unit_sel, 2'b10);
        tick();
        flush = 1;
        #1 chk("div_flush_valid", out_valid, 0);
        chk("div_flush_cancel_early", unit_cancel, 0);
        tick();
        flush = 0;
        #1 chk("div_cancel", unit_cancel, 2'b10);
        chk("div_empty", in_ready, 1);
        tick();
        chk("div_cancel_once", unit_cancel, 0);
        out_ready = 1; unit_req_ready = 0;

        // Flush while issuing: no handshake, no cancel
        in_valid = 1; in_payload = 128'hE1; in_unit_sel = 2'b01; unit_req_ready = 2'b01;
        tick();
        in_valid = 0; flush = 1;
        #1 chk("iflush_req", unit_req_valid, 0);
        tick();
        flush = 0;
        #1 chk("iflush_cancel", unit_cancel, 0);
        chk("iflush_ready", in_ready, 1);
        in_valid = 1; in_payload = 128'hE2; in_unit_sel = 2'b00;
        tick();
        chk("iflush_next_valid", out_valid, 1);
        chk("iflush_next_payload", out_payload, 128'hE2);
        chk("iflush_cancel2", unit_cancel, 0);
        in_valid = 0; unit_req_ready = 0;
        tick();

        // Asynchronous reset mid-issue
        in_valid = 1; in_payload = 128'hF1; in_unit_sel = 2'b01;
        tick();
        in_valid = 0;
        tick(); tick();
        #1 resetn = 0;
        #1 chk("areset_req", unit_req_valid, 0);
        chk("areset_stall", stall_cnt, 0);
        chk("areset_valid", out_valid, 0);
        chk("areset_ready", in_ready, 1);
        chk("areset_payload", out_payload, 0);
        #1 resetn = 1;
        tick();
        chk("areset_cancel", unit_cancel, 0);
        chk("areset_idle", unit_req_valid, 0);

        // Saturation of a narrow counter after 20 stalls
        in_valid = 1; in_payload = 128'h51; in_unit_sel = 2'b01; unit_req_ready = 0;
        tick();
        in_valid = 0;
        repeat (20) tick();
        chk("sat_small", s_stall_cnt, 4'hF);
        chk("sat_wide", stall_cnt, 20);
        unit_req_ready = 2'b01;
        tick();
        unit_req_ready = 0;
        chk("sat_unit_sel", out_unit_sel, 2'b01);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
